// File: rtl/inst_rom_loader.sv
// Byte-stream loader: parses a length-prefixed image and writes 9-bit words into the instruction memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module inst_rom_loader #(
  parameter int ADDR_W = 10,
  parameter int INST_W = 9
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [7:0]        InByte,
  input  logic              InValid,
  output logic              InReady,
  output logic              InstWrEn,
  output logic [ADDR_W-1:0] InstWrAddr,
  output logic [INST_W-1:0] InstWrData,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_INST_LO, S_INST_HI, S_WRITE, S_DONE, S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t          state, state_nxt;
  logic [ADDR_W:0] cnt;
  logic [15:0]     len;
  logic [7:0]      len_lo;
  logic [7:0]      inst_lo;
  logic            xfer;
  logic [15:0]     len_in;
  logic            last_word;
  logic            start_ok;

  assign xfer      = InValid && InReady;
  assign len_in    = {InByte, len_lo};
  assign last_word = (17'(cnt) + 17'd1) == {1'b0, len};
  assign start_ok  = Start && (state == S_IDLE || state == S_DONE || state == S_ERR);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (Start) state_nxt = S_LEN_LO;
      S_LEN_LO:  if (xfer) state_nxt = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if (len_in == 16'd0)                state_nxt = S_DONE;
          else if ({1'b0, len_in} > CAP)      state_nxt = S_ERR;
          else                                state_nxt = S_INST_LO;
        end
      end
      S_INST_LO: if (xfer) state_nxt = S_INST_HI;
      S_INST_HI: begin
        if (xfer) state_nxt = (InByte[7:1] != 7'd0) ? S_ERR : S_WRITE;
      end
      S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        state_nxt = last_word ? S_CHK : S_INST_LO;
`else
        state_nxt = last_word ? S_DONE : S_INST_LO;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (xfer) state_nxt = (InByte == csum) ? S_DONE : S_ERR;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with the state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      InReady    <= 1'b0;
      InstWrEn   <= 1'b0;
      InstWrAddr <= '0;
      InstWrData <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      cnt        <= '0;
      len        <= '0;
      len_lo     <= '0;
      inst_lo    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state    <= state_nxt;
      InReady  <= (state_nxt == S_LEN_LO) || (state_nxt == S_LEN_HI) ||
                  (state_nxt == S_INST_LO) || (state_nxt == S_INST_HI)
`ifdef LOADER_CHECKSUM_EN
                  || (state_nxt == S_CHK)
`endif
                  ;
      Busy     <= !(state_nxt == S_IDLE || state_nxt == S_DONE || state_nxt == S_ERR);
      Done     <= (state_nxt == S_DONE);
      Error    <= (state_nxt == S_ERR);
      InstWrEn <= (state_nxt == S_WRITE);

      case (state)
        S_LEN_LO: if (xfer) len_lo <= InByte;
        S_LEN_HI: begin
          if (xfer) begin
            len <= len_in;
            cnt <= '0;
          end
        end
        S_INST_LO: if (xfer) inst_lo <= InByte;
        S_INST_HI: begin
          if (xfer) begin
            InstWrAddr <= cnt[ADDR_W-1:0];
            InstWrData <= INST_W'({InByte[0], inst_lo});
          end
        end
        S_WRITE: cnt <= cnt + 1'b1;
        default: ;
      endcase

`ifdef LOADER_CHECKSUM_EN
      if (start_ok)  csum <= '0;
      else if (xfer) csum <= csum ^ InByte;
`endif
    end
  end

`ifndef LOADER_CHECKSUM_EN
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: table vectors, cycle-exact corner sequences and
// randomized images checked against an image-parsing reference model.
module tb_inst_rom_loader;

  localparam int ADDR_W = 10;
  localparam int INST_W = 9;
`ifdef LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  typedef logic [7:0] byte_q[$];
  typedef struct { int addr; int data; } wr_t;
  typedef struct {
    int          len;
    logic [95:0] b;
    bit          done;
    int          nwr;
    int          first;
    int          last;
  } vec_t;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Start = 1'b0;
  logic [7:0]        InByte = '0;
  logic              InValid = 1'b0;
  logic              InReady;
  logic              InstWrEn;
  logic [ADDR_W-1:0] InstWrAddr;
  logic [INST_W-1:0] InstWrData;
  logic              Busy;
  logic              Done;
  logic              Error;

  int total = 0;
  int bad   = 0;
  wr_t wr_q[$];
  wr_t exp_q[$];
  bit  exp_ok;

  inst_rom_loader #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .InByte(InByte), .InValid(InValid),
    .InReady(InReady), .InstWrEn(InstWrEn), .InstWrAddr(InstWrAddr), .InstWrData(InstWrData),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (InstWrEn) wr_q.push_back('{int'(InstWrAddr), int'(InstWrData)});

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic byte_q finish_img(input byte_q img);
    byte_q r = img;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x = '0;
    foreach (img[i]) x ^= img[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  // Reference: parse the image straight from the format rules.
  function automatic void model(input byte_q img);
    int n;
    logic [7:0] x, lo, hi;
    exp_q.delete();
    n = int'(img[0]) + 256 * int'(img[1]);
    x = img[0] ^ img[1];
    if (n == 0) begin exp_ok = 1; return; end
    if (n > (1 << ADDR_W)) begin exp_ok = 0; return; end
    for (int i = 0; i < n; i++) begin
      lo = img[2 + 2*i];
      hi = img[3 + 2*i];
      x ^= lo ^ hi;
      if (hi > 8'd1) begin exp_ok = 0; return; end
      exp_q.push_back('{i, int'(hi) * 256 + int'(lo)});
    end
`ifdef LOADER_CHECKSUM_EN
    exp_ok = (img[2 + 2*n] == x);
`else
    exp_ok = 1;
`endif
  endfunction

  task automatic run_load(input byte_q img, input int gap, input bit extra_start);
    int idx = 0;
    int cyc = 0;
    bit xf;
    wr_q.delete();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    while (cyc < 8000 && Busy) begin
      if (idx < img.size() && int'($urandom_range(99)) >= gap) begin
        InValid = 1'b1;
        InByte  = img[idx];
      end else begin
        InValid = 1'b0;
        InByte  = 8'($urandom);
      end
      Start = extra_start && (cyc == 5);
      xf = InValid && InReady;
      tick();
      cyc++;
      if (xf) idx++;
    end
    InValid = 1'b0;
    Start   = 1'b0;
    if (cyc >= 8000) check("load_timeout", 1, 0);
  endtask

  task automatic compare_model(input string name);
    check({name, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      check({name, "_addr"}, wr_q[i].addr, exp_q[i].addr);
      check({name, "_data"}, wr_q[i].data, exp_q[i].data);
    end
    check({name, "_done"}, int'(Done), int'(exp_ok));
    check({name, "_err"}, int'(Error), int'(!exp_ok));
  endtask

  vec_t vt[8];

  initial begin
    byte_q img, n3;
    int    n, done_cyc, idx;
    int    wcyc[$];
    bit    xf;

    vt[0] = '{8,  96'h03_00_25_01_FF_00_00_01_00_00_00_00, 1, 3, 'h125, 'h100};
    vt[1] = '{2,  96'h00_00_00_00_00_00_00_00_00_00_00_00, 1, 0, 0, 0};
    vt[2] = '{2,  96'h01_04_00_00_00_00_00_00_00_00_00_00, 0, 0, 0, 0};
    vt[3] = '{6,  96'h04_00_11_00_22_02_00_00_00_00_00_00, 0, 1, 'h011, 'h011};
    vt[4] = '{4,  96'h01_00_AA_01_00_00_00_00_00_00_00_00, 1, 1, 'h1AA, 'h1AA};
    vt[5] = '{4,  96'h02_00_33_80_00_00_00_00_00_00_00_00, 0, 0, 0, 0};
    vt[6] = '{2,  96'hFF_FF_00_00_00_00_00_00_00_00_00_00, 0, 0, 0, 0};
    vt[7] = '{6,  96'h02_00_00_00_FF_01_00_00_00_00_00_00, 1, 2, 'h000, 'h1FF};

    // Reset state
    tick(); tick();
    check("reset_outs", int'({InReady, InstWrEn, InstWrAddr, InstWrData, Busy, Done, Error}), 0);
    Reset_n = 1'b1;
    tick();

    // Table vectors
    foreach (vt[v]) begin
      img.delete();
      for (int i = 0; i < vt[v].len; i++) img.push_back(vt[v].b[95 - 8*i -: 8]);
      run_load(finish_img(img), 0, 0);
      check($sformatf("vec%0d_done", v), int'(Done), int'(vt[v].done));
      check($sformatf("vec%0d_err", v), int'(Error), int'(!vt[v].done));
      check($sformatf("vec%0d_nwr", v), wr_q.size(), vt[v].nwr);
      check($sformatf("vec%0d_ready", v), int'(InReady), 0);
      if (wr_q.size() > 0 && vt[v].nwr > 0) begin
        check($sformatf("vec%0d_first", v), wr_q[0].data, vt[v].first);
        check($sformatf("vec%0d_last", v), wr_q[wr_q.size()-1].data, vt[v].last);
        check($sformatf("vec%0d_addr0", v), wr_q[0].addr, 0);
      end
    end

    // Cycle-exact N=3 run with InValid held high
    n3 = finish_img('{8'h03, 8'h00, 8'h25, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h01});
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("ready_after_start", int'(InReady), 1);
    check("busy_after_start", int'(Busy), 1);
    idx = 0;
    done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      InValid = (idx < n3.size());
      InByte  = InValid ? n3[idx] : 8'h00;
      xf = InValid && InReady;
      tick();
      if (xf) idx++;
      if (InstWrEn) wcyc.push_back(c);
      if (Done && done_cyc < 0) begin
        done_cyc = c;
        check("busy_at_done", int'(Busy), 0);
      end
    end
    InValid = 1'b0;
    check("t_nwr", wcyc.size(), 3);
    for (int i = 0; i < wcyc.size(); i++) check("t_wr_cycle", wcyc[i], 4 + 3*i);
    check("t_done_cycle", done_cyc, 11 + CS);

    // Reset in the middle of an N=8 load
    img = '{8'h08, 8'h00};
    for (int i = 0; i < 8; i++) begin img.push_back(8'(i + 1)); img.push_back(8'h00); end
    img = finish_img(img);
    wr_q.delete();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    idx = 0;
    for (int c = 0; c < 100 && wr_q.size() < 3; c++) begin
      InValid = 1'b1;
      InByte  = img[idx];
      xf = InReady;
      tick();
      if (xf) idx++;
    end
    check("mid_writes", wr_q.size(), 3);
    InValid = 1'b0;
    Reset_n = 1'b0;
    tick();
    check("midreset_outs", int'({InReady, InstWrEn, InstWrAddr, InstWrData, Busy, Done, Error}), 0);
    Reset_n = 1'b1;
    tick();
    model(n3);
    run_load(n3, 0, 0);
    compare_model("after_reset");

    // Full capacity image
    img = '{8'h00, 8'h04};
    for (int i = 0; i < 1024; i++) begin img.push_back(8'(i)); img.push_back(8'((i >> 8) & 1)); end
    img = finish_img(img);
    model(img);
    run_load(img, 0, 0);
    compare_model("full");
    if (wr_q.size() > 0) check("full_last_addr", wr_q[wr_q.size()-1].addr, 1023);

    // Gapped run with a Start pulse while Busy
    model(n3);
    run_load(n3, 40, 1);
    compare_model("gap_start");

`ifdef LOADER_CHECKSUM_EN
    model('{8'h01, 8'h00, 8'hAA, 8'h01, 8'hAA});
    run_load('{8'h01, 8'h00, 8'hAA, 8'h01, 8'hAA}, 0, 0);
    compare_model("cs_good");
    check("cs_good_done", int'(Done), 1);
    run_load('{8'h01, 8'h00, 8'hAA, 8'h01, 8'hAB}, 0, 0);
    check("cs_bad_err", int'(Error), 1);
    check("cs_bad_nwr", wr_q.size(), 1);
    if (wr_q.size() > 0) check("cs_bad_addr", wr_q[0].addr, 0);
`endif

    // Randomized images against the reference model
    for (int t = 0; t < 25; t++) begin
      n = int'($urandom_range(1, 20));
      img = '{8'(n), 8'h00};
      for (int i = 0; i < n; i++) begin
        img.push_back(8'($urandom));
        if ($urandom_range(19) == 0) img.push_back(8'h02 | 8'($urandom_range(255)));
        else                         img.push_back(8'($urandom_range(1)));
      end
      img = finish_img(img);
`ifdef LOADER_CHECKSUM_EN
      if ($urandom_range(3) == 0) img[img.size()-1] = img[img.size()-1] ^ 8'h10;
`endif
      model(img);
      run_load(img, int'($urandom_range(50)), ($urandom_range(1) == 1));
      compare_model($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
